mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// Memory stage plus MEM/WB pipeline register, directly upstream of the writeback mux.
// Issues load/store requests to data memory over a req/rsp handshake and stalls the
// pipeline while a response is outstanding. Aligns and extends load data, then registers
// RegWriteW, ResultSrcW, ALUResultW, RdataW, RdW and PCPlus4W for writeback.
// PARAMETERS
// XLEN  32  datapath width; only 32 is supported.
// PORTS
// clk            in   1     clock, rising edge
// rst_n          in   1     asynchronous active-low reset
// ValidM         in   1     instruction in M stage is valid
// RegWriteM      in   1     instruction writes rd
// ResultSrcM     in   2     00 ALU, 01 load data, 10 PC+4; 01 marks a load
// MemWriteM      in   1     instruction is a store
// Funct3M        in   3     load/store size and sign (RV32I encoding)
// ALUResultM     in   32    effective address or ALU result
// WriteDataM     in   32    store data (rs2)
// RdM            in   5     destination register
// PCPlus4M       in   32    PC+4 of the instruction
// dmem_req       out  1     memory request valid
// dmem_we        out  1     1 = store, 0 = load
// dmem_addr      out  32    {ALUResultM[31:2],2'b00}
// dmem_be        out  4     byte enables
// dmem_wdata     out  32    lane-replicated store data
// dmem_rsp_valid in   1     response/completion this cycle (same cycle as req allowed)
// dmem_rdata     in   32    read word, valid with dmem_rsp_valid
// StallM         out  1     freeze F/D/E/M stages this cycle
// RegWriteW/ResultSrcW/ALUResultW/RdataW/RdW/PCPlus4W  out  1/2/32/32/5/32  W-stage regs
// BEHAVIOUR
// - Mem op = ValidM & (MemWriteM | ResultSrcM==2'b01). Non-mem ops pass straight through.
// - FSM IDLE/WAIT. IDLE: mem op -> dmem_req=1 (combinational); rsp_valid same cycle -> done,
//   stay IDLE, StallM=0; else -> WAIT, StallM=1. WAIT: dmem_req, addr, be, we, wdata held
//   stable from M inputs (frozen by StallM); StallM=1 until rsp_valid, that cycle StallM=0,
//   -> IDLE. rsp_valid in IDLE without mem op is ignored.
// - Store be: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111 (a=ALUResultM).
//   wdata: SB {4{b}}, SH {2{h}}, SW word. Loads: be per same rule, we=0.
// - Load extract: byte lane a[1:0], half lane a[1]; LB/LH sign-extend, LBU/LHU zero-extend,
//   LW whole word. Undefined funct3 -> whole word.
// - W register updates every clk when StallM=0, capturing M inputs and aligned RdataW.
//   RegWriteW = RegWriteM & ValidM. While StallM=1, W gets a bubble: RegWriteW=0, other W
//   regs hold. Latency: 1 cycle from completion (rsp) edge to W valid.
// - Reset (async, rst_n=0): state IDLE; all W outputs 0; dmem_req=0, StallM=0 while in reset.
//   Reset mid-WAIT abandons the request; a later stray rsp_valid is ignored.
// CONFIGURATION
// MISALIGN_CHECK_EN defined: LH/LHU/SH with a[0]=1 or LW/SW with a[1:0]!=0 issue no
//   request, no stall, force RegWriteW=0 and pulse output misalign_o (1 bit, reg, reset 0)
//   for one cycle as instruction enters W.
// Not defined: no misalign_o port; low address bits beyond the lane select are ignored,
//   access proceeds as aligned.
// TESTING
// - LW a=0x100, rsp same cycle rdata=0xDEADBEEF -> StallM never 1; next cycle RdataW=0xDEADBEEF, RegWriteW=1.
// - LB a=0x103, rdata=0x80FF_FF00, rsp after 3 cycles -> StallM=1 for 3 cycles, RegWriteW=0 bubbles,
//   then RdataW=0xFFFFFF80.
// - LHU a=0x102 rdata=0xBEEF1234 -> RdataW=0x0000BEEF; LH same -> 0xFFFFBEEF.
// - SB a=0x201 data=0x5A -> dmem_be=4'b0010, dmem_wdata=0x5A5A5A5A, dmem_we=1; RegWriteW=0.
// - Assert rst_n=0 during WAIT -> next cycles state IDLE, dmem_req=0, W regs 0; late rsp ignored.
// - MISALIGN_CHECK_EN: LW a=0x102 -> dmem_req=0, misalign_o=1 one cycle, RegWriteW=0.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: data-memory request/response channel between the memory stage and data memory.
interface dmem_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, be, wdata, input rsp_valid, rdata);
  modport slave(input req, we, addr, be, wdata, output rsp_valid, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory stage with req/rsp data-memory handshake, load alignment and MEM/WB register.
// Optional MISALIGN_CHECK_EN suppresses misaligned accesses and flags them on misalign_o.
module mem_stage #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  dmem_if.master          dmem,
`ifdef MISALIGN_CHECK_EN
  output logic            misalign_o,
`endif
  output logic            StallM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] RdataW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] PCPlus4W
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [1:0] lane, sz;
  logic mem_op, misalign, go;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [XLEN-1:0] load_data;
  assign lane = ALUResultM[1:0];
  assign sz = Funct3M[1:0];
  assign mem_op = ValidM & (MemWriteM | ResultSrcM == 2'b01);
`ifdef MISALIGN_CHECK_EN
  assign misalign = mem_op & ((sz == 2'b01 & lane[0]) | (sz == 2'b10 & lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign go = mem_op & ~misalign;
  assign dmem.addr = {ALUResultM[31:2], 2'b00};
  assign dmem.we = MemWriteM;
  assign dmem.be = sz == 2'b00 ? 4'b0001 << lane :
                   sz == 2'b01 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
  assign dmem.wdata = sz == 2'b00 ? {4{WriteDataM[7:0]}} :
                      sz == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
  assign byte_v = dmem.rdata[{lane, 3'b000} +: 8];
  assign half_v = dmem.rdata[{lane[1], 4'b0000} +: 16];
  assign load_data = Funct3M == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                     Funct3M == 3'b001 ? {{16{half_v[15]}}, half_v} :
                     Funct3M == 3'b100 ? {24'b0, byte_v} :
                     Funct3M == 3'b101 ? {16'b0, half_v} : dmem.rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Request is held in WAIT because StallM freezes the M inputs that drive it.
  always_comb begin
    dmem.req = rst_n & (state == WAIT | go);
    StallM = dmem.req & ~dmem.rsp_valid;
    state_n = StallM ? WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      RdataW     <= '0;
      RdW        <= 5'd0;
      PCPlus4W   <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else if (!StallM) begin
      RegWriteW  <= RegWriteM & ValidM & ~misalign;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      RdataW     <= load_data;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
`ifdef MISALIGN_CHECK_EN
      misalign_o <= misalign;
`endif
    end else begin
      RegWriteW  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic clk, rst_n, ValidM, RegWriteM, MemWriteM, StallM, RegWriteW;
  logic [1:0] ResultSrcM, ResultSrcW;
  logic [2:0] Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ALUResultW, RdataW, PCPlus4W;
  logic [4:0] RdM, RdW;
`ifdef MISALIGN_CHECK_EN
  logic misalign_o;
`endif
  int checks = 0, failures = 0;
  dmem_if bus();
  mem_stage dut(
    .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M), .dmem(bus.master),
`ifdef MISALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .RdataW(RdataW), .RdW(RdW), .PCPlus4W(PCPlus4W));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] rd, input logic rsp, input logic [31:0] rdata);
    ValidM = v; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
    ALUResultM = a; WriteDataM = wd; RdM = rd; PCPlus4M = a + 32'd4;
    bus.rsp_valid = rsp; bus.rdata = rdata;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0;
    op(0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_req", bus.req, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_regw", RegWriteW, 0);
    chk("rst_rdata", RdataW, 0);
    tick;
    rst_n = 1;
    // LW same-cycle response
    op(1, 1, 2'b01, 0, 3'b010, 32'h100, 0, 5'd3, 1, 32'hDEADBEEF);
    @(negedge clk);
    chk("lw_req", bus.req, 1);
    chk("lw_stall", StallM, 0);
    chk("lw_addr", bus.addr, 32'h100);
    chk("lw_be", bus.be, 4'b1111);
    chk("lw_we", bus.we, 0);
    tick;
    op(0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lw_rdataw", RdataW, 32'hDEADBEEF);
    chk("lw_regw", RegWriteW, 1);
    chk("lw_rdw", RdW, 5'd3);
    chk("lw_srcw", ResultSrcW, 2'b01);
    // LB with response after three stalled cycles
    tick;
    op(1, 1, 2'b01, 0, 3'b000, 32'h103, 0, 5'd7, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lb_stall", StallM, 1);
      chk("lb_be", bus.be, 4'b1000);
      tick;
      chk("lb_bubble", RegWriteW, 0);
    end
    bus.rsp_valid = 1; bus.rdata = 32'h80FFFF00;
    @(negedge clk);
    chk("lb_done_stall", StallM, 0);
    tick;
    op(0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lb_rdataw", RdataW, 32'hFFFFFF80);
    chk("lb_regw", RegWriteW, 1);
    // LHU / LH upper half
    tick;
    op(1, 1, 2'b01, 0, 3'b101, 32'h102, 0, 5'd8, 1, 32'hBEEF1234);
    tick;
    chk("lhu_rdataw", RdataW, 32'h0000BEEF);
    op(1, 1, 2'b01, 0, 3'b001, 32'h102, 0, 5'd8, 1, 32'hBEEF1234);
    tick;
    chk("lh_rdataw", RdataW, 32'hFFFFBEEF);
    op(1, 1, 2'b01, 0, 3'b100, 32'h101, 0, 5'd8, 1, 32'h00008100);
    tick;
    chk("lbu_rdataw", RdataW, 32'h00000081);
    // SB / SH stores
    op(1, 0, 2'b00, 1, 3'b000, 32'h201, 32'h0000005A, 5'd0, 1, 0);
    @(negedge clk);
    chk("sb_be", bus.be, 4'b0010);
    chk("sb_wdata", bus.wdata, 32'h5A5A5A5A);
    chk("sb_we", bus.we, 1);
    chk("sb_addr", bus.addr, 32'h200);
    tick;
    chk("sb_regw", RegWriteW, 0);
    op(1, 0, 2'b00, 1, 3'b001, 32'h202, 32'hFFFF1234, 5'd0, 1, 0);
    @(negedge clk);
    chk("sh_be", bus.be, 4'b1100);
    chk("sh_wdata", bus.wdata, 32'h12341234);
    tick;
    // Non-memory op with stray response passes straight through
    op(1, 1, 2'b10, 0, 3'b000, 32'h440, 0, 5'd9, 1, 32'h11111111);
    @(negedge clk);
    chk("alu_req", bus.req, 0);
    chk("alu_stall", StallM, 0);
    tick;
    chk("alu_regw", RegWriteW, 1);
    chk("alu_pc4w", PCPlus4W, 32'h444);
    chk("alu_aluw", ALUResultW, 32'h440);
    op(0, 1, 2'b00, 0, 3'b000, 32'h10, 0, 5'd9, 0, 0);
    tick;
    chk("inval_regw", RegWriteW, 0);
    // Reset while waiting on a load
    op(1, 1, 2'b01, 0, 3'b010, 32'h300, 0, 5'd4, 0, 0);
    tick;
    chk("wait_stall", StallM, 1);
    rst_n = 0;
    #1;
    chk("rstw_req", bus.req, 0);
    chk("rstw_stall", StallM, 0);
    chk("rstw_aluw", ALUResultW, 0);
    chk("rstw_rdw", RdW, 0);
    tick;
    op(0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
    rst_n = 1;
    bus.rsp_valid = 1; bus.rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_rsp_req", bus.req, 0);
    chk("late_rsp_stall", StallM, 0);
    tick;
    chk("late_rsp_regw", RegWriteW, 0);
    op(1, 1, 2'b01, 0, 3'b010, 32'h104, 0, 5'd5, 0, 0);
    @(negedge clk);
    chk("post_rst_stall", StallM, 1);
    bus.rsp_valid = 1; bus.rdata = 32'h0BADCAFE;
    tick;
    op(0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
    chk("post_rst_rdataw", RdataW, 32'h0BADCAFE);
`ifdef MISALIGN_CHECK_EN
    op(1, 1, 2'b01, 0, 3'b010, 32'h102, 0, 5'd6, 0, 0);
    @(negedge clk);
    chk("mis_req", bus.req, 0);
    chk("mis_stall", StallM, 0);
    tick;
    op(0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
    chk("mis_flag", misalign_o, 1);
    chk("mis_regw", RegWriteW, 0);
    tick;
    chk("mis_flag_clr", misalign_o, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
